// File: rtl/cim_pkg.sv
// Shared CIM definitions: default tile widths, output-buffer state encoding and
// an unsigned saturate helper.
package cim_pkg;

    localparam int unsigned CIM_DATA_WIDTH = 8;
    localparam int unsigned CIM_XBAR_SIZE  = 128;
    localparam int unsigned CIM_V_TILES    = 1;
    localparam int unsigned CIM_ADC_WIDTH  = 8;
    localparam int unsigned CIM_OUT_SHIFT  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        QUANT,
        DRAIN
    } obuf_state_t;

    // Clamp an unsigned value to the largest code representable in w bits.
    function automatic logic [63:0] sat_u(input logic [63:0] v, input int unsigned w);
        logic [63:0] lim;
        lim = (64'(1) << w) - 64'(1);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/fc_obuf_if.sv
// Crossbar-result input and next-layer write port of the FC output buffer.
interface fc_obuf_if
    import cim_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CIM_DATA_WIDTH,
    parameter int unsigned XBAR_SIZE  = CIM_XBAR_SIZE,
    parameter int unsigned V_TILES    = CIM_V_TILES,
    parameter int unsigned ADC_WIDTH  = CIM_ADC_WIDTH
);
    logic                                    i_start;
    logic                                    i_valid;
    logic [V_TILES*XBAR_SIZE*ADC_WIDTH-1:0]  i_adc_data;
    logic                                    i_stall;
    logic                                    o_we;
    logic [DATA_WIDTH-1:0]                   o_data;
    logic                                    o_busy;
    logic                                    o_done;

    modport master (
        output i_start, i_valid, i_adc_data, i_stall,
        input  o_we, o_data, o_busy, o_done
    );

    modport slave (
        input  i_start, i_valid, i_adc_data, i_stall,
        output o_we, o_data, o_busy, o_done
    );

endinterface

// File: rtl/fc_obuf_lane.sv
// One output element: bit-slice recombination, shift-accumulate over input
// bit-planes and requantize/saturate.
module fc_obuf_lane
    import cim_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CIM_DATA_WIDTH,
    parameter int unsigned V_TILES    = CIM_V_TILES,
    parameter int unsigned ADC_WIDTH  = CIM_ADC_WIDTH,
    parameter int unsigned OUT_SHIFT  = CIM_OUT_SHIFT,
    parameter int unsigned ACC_WIDTH  = ADC_WIDTH + 2*DATA_WIDTH + 1,
    parameter int unsigned BCW        = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clr,
    input  logic                                  acc_en,
    input  logic [BCW-1:0]                        bit_cnt,
    input  logic [V_TILES*DATA_WIDTH*ADC_WIDTH-1:0] cols,
    input  logic                                  quant_en,
    output logic [DATA_WIDTH-1:0]                 q
);

    logic [ACC_WIDTH-1:0]  psum;
    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  acc_shr;
    logic [DATA_WIDTH-1:0] q_sat;

    // Column b of each tile carries weight bit b.
    always_comb begin
        psum = '0;
        for (int v = 0; v < int'(V_TILES); v++) begin
            for (int b = 0; b < int'(DATA_WIDTH); b++) begin
                psum = psum + (ACC_WIDTH'(cols[(v*int'(DATA_WIDTH) + b)*int'(ADC_WIDTH) +: ADC_WIDTH]) << b);
            end
        end
    end

    always_comb begin
        acc_shr = acc >> OUT_SHIFT;
        q_sat   = DATA_WIDTH'(sat_u(64'(acc_shr), DATA_WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            q   <= '0;
        end else begin
            if (clr) begin
                acc <= '0;
            end else if (acc_en) begin
                acc <= acc + (psum << bit_cnt);
            end
            if (quant_en) begin
                q <= q_sat;
            end
        end
    end

endmodule

// File: rtl/fc_obuf.sv
// FC-layer output buffer: accumulates bit-serial crossbar results per element,
// requantizes, and drains highest element first into the next input buffer.
module fc_obuf
    import cim_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CIM_DATA_WIDTH,
    parameter int unsigned XBAR_SIZE  = CIM_XBAR_SIZE,
    parameter int unsigned V_TILES    = CIM_V_TILES,
    parameter int unsigned ADC_WIDTH  = CIM_ADC_WIDTH,
    parameter int unsigned OUT_SHIFT  = CIM_OUT_SHIFT
) (
    input  logic     clk,
    input  logic     rst,
    fc_obuf_if.slave bus
);

    localparam int unsigned FIFO_LENGTH = XBAR_SIZE / DATA_WIDTH;
    localparam int unsigned ACC_WIDTH   = ADC_WIDTH + 2*DATA_WIDTH + $clog2(V_TILES) + 1;
    localparam int unsigned BCW         = $clog2(DATA_WIDTH + 1);
    localparam int unsigned OCW         = $clog2(FIFO_LENGTH + 1);
    localparam int unsigned TILE_W      = DATA_WIDTH * ADC_WIDTH;
    localparam int unsigned LANE_W      = V_TILES * TILE_W;

    obuf_state_t           state, state_n;
    logic [BCW-1:0]        bit_cnt, bit_cnt_n;
    logic [OCW-1:0]        out_cnt, out_cnt_n;
    logic                  we_q, we_n;
    logic [DATA_WIDTH-1:0] data_q, data_n;
    logic                  busy_q, busy_n;
    logic                  done_q, done_n;
    logic                  lane_clr, lane_acc, lane_quant;
    logic [DATA_WIDTH-1:0] lane_q [FIFO_LENGTH];
    logic [DATA_WIDTH-1:0] drain_sel;

    for (genvar e = 0; e < FIFO_LENGTH; e++) begin : g_lane
        logic [LANE_W-1:0] cols;
        for (genvar v = 0; v < V_TILES; v++) begin : g_tile
            assign cols[v*TILE_W +: TILE_W] =
                bus.i_adc_data[(v*XBAR_SIZE + e*DATA_WIDTH)*ADC_WIDTH +: TILE_W];
        end
        fc_obuf_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .V_TILES    (V_TILES),
            .ADC_WIDTH  (ADC_WIDTH),
            .OUT_SHIFT  (OUT_SHIFT),
            .ACC_WIDTH  (ACC_WIDTH),
            .BCW        (BCW)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clr      (lane_clr),
            .acc_en   (lane_acc),
            .bit_cnt  (bit_cnt),
            .cols     (cols),
            .quant_en (lane_quant),
            .q        (lane_q[e])
        );
    end

    // Element FIFO_LENGTH-1-out_cnt goes out next.
    always_comb begin
        drain_sel = '0;
        for (int e = 0; e < int'(FIFO_LENGTH); e++) begin
            if (OCW'(int'(FIFO_LENGTH) - 1 - e) == out_cnt) begin
                drain_sel = lane_q[e];
            end
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        out_cnt_n  = out_cnt;
        we_n       = 1'b0;
        data_n     = data_q;
        done_n     = 1'b0;
        lane_clr   = 1'b0;
        lane_acc   = 1'b0;
        lane_quant = 1'b0;
        case (state)
            IDLE: begin
                lane_clr  = 1'b1;
                bit_cnt_n = '0;
                // A start coinciding with the visible done pulse is dropped.
                if (bus.i_start && !done_q) begin
                    state_n = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.i_valid) begin
                    lane_acc  = 1'b1;
                    bit_cnt_n = bit_cnt + BCW'(1);
                    if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
                        state_n = QUANT;
                    end
                end
            end
            QUANT: begin
                lane_quant = 1'b1;
                out_cnt_n  = '0;
                state_n    = DRAIN;
            end
            DRAIN: begin
                if (out_cnt == OCW'(FIFO_LENGTH)) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (!bus.i_stall) begin
                    we_n      = 1'b1;
                    data_n    = drain_sel;
                    out_cnt_n = out_cnt + OCW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            out_cnt <= '0;
            we_q    <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            out_cnt <= out_cnt_n;
            we_q    <= we_n;
            data_q  <= data_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign bus.o_we   = we_q;
    assign bus.o_data = data_q;
    assign bus.o_busy = busy_q;
    assign bus.o_done = done_q;

endmodule

// File: tb/tb_fc_obuf.sv
// Bench for fc_obuf: two instances (OUT_SHIFT 0 and 4) share stimulus and are
// compared against an arithmetic reference of the accumulate/requantize rules.
module tb_fc_obuf;

    localparam int unsigned DW = 4;
    localparam int unsigned XS = 8;
    localparam int unsigned VT = 1;
    localparam int unsigned AW = 4;
    localparam int unsigned NB = VT * XS * AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          valid;
    logic [NB-1:0] adc;
    logic          stall;

    int total  = 0;
    int passed = 0;
    int cyc_cnt = 0;
    logic [NB-1:0] bt [4];

    fc_obuf_if #(.DATA_WIDTH(DW), .XBAR_SIZE(XS), .V_TILES(VT), .ADC_WIDTH(AW)) bus0 ();
    fc_obuf_if #(.DATA_WIDTH(DW), .XBAR_SIZE(XS), .V_TILES(VT), .ADC_WIDTH(AW)) bus1 ();

    assign bus0.i_start = start;
    assign bus0.i_valid = valid;
    assign bus0.i_adc_data = adc;
    assign bus0.i_stall = stall;
    assign bus1.i_start = start;
    assign bus1.i_valid = valid;
    assign bus1.i_adc_data = adc;
    assign bus1.i_stall = stall;

    fc_obuf #(.DATA_WIDTH(DW), .XBAR_SIZE(XS), .V_TILES(VT), .ADC_WIDTH(AW), .OUT_SHIFT(0))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    fc_obuf #(.DATA_WIDTH(DW), .XBAR_SIZE(XS), .V_TILES(VT), .ADC_WIDTH(AW), .OUT_SHIFT(4))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Element e = weighted sum of its DW columns over all bit-planes, then >> sh, clamped.
    function automatic int unsigned ref_q(input int e, input int sh);
        longint unsigned acc;
        logic [NB-1:0] w;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            w = bt[k];
            for (int b = 0; b < 4; b++) begin
                acc += longint'(w[(e*4 + b)*4 +: 4]) << (b + k);
            end
        end
        acc = acc >> sh;
        return (acc > 15) ? 15 : int'(acc);
    endfunction

    task automatic run_vector(input string tag, input bit gaps, input bit stl, input bit abuse);
        int n;
        int wcyc [2];
        logic [3:0] d0 [2];
        logic [3:0] d1 [2];
        bit got_done;
        int done_cyc;
        int last_beat;
        n = 0; got_done = 0; done_cyc = 0;
        wcyc[0] = 0; wcyc[1] = 0;
        d0[0] = 0; d0[1] = 0; d1[0] = 0; d1[1] = 0;
        // valid data while idle must not leak into the next vector
        valid = 1'b1; adc = NB'($urandom); tick(); valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (gaps) begin
                valid = 1'b0; adc = NB'($urandom);
                if (abuse) start = 1'b1;
                tick(); start = 1'b0;
            end
            valid = 1'b1; adc = bt[k];
            if (abuse && k == 1) start = 1'b1;
            tick(); start = 1'b0; valid = 1'b0;
        end
        last_beat = cyc_cnt;
        adc = NB'($urandom);
        for (int t = 0; t < 40 && !got_done; t++) begin
            tick(); start = 1'b0; valid = 1'b0;
            if (bus0.o_done) begin
                got_done = 1;
                done_cyc = cyc_cnt;
            end else if (bus0.o_we) begin
                if (n < 2) begin
                    d0[n] = bus0.o_data; d1[n] = bus1.o_data; wcyc[n] = cyc_cnt;
                end
                n++;
                if (n == 1) begin
                    chk({tag, "_busy_drain"}, 32'(bus0.o_busy), 1);
                    if (abuse) begin start = 1'b1; valid = 1'b1; adc = NB'($urandom); end
                    if (stl) begin
                        stall = 1'b1;
                        for (int s = 0; s < 3; s++) begin
                            tick(); start = 1'b0; valid = 1'b0;
                            chk({tag, "_stall_we"}, 32'(bus0.o_we), 0);
                            chk({tag, "_stall_hold"}, 32'(bus0.o_data), 32'(d0[0]));
                        end
                        stall = 1'b0;
                    end
                end
            end
        end
        chk({tag, "_done_seen"}, 32'(got_done), 1);
        chk({tag, "_nwrites"}, 32'(n), 2);
        chk({tag, "_e1_s0"}, 32'(d0[0]), ref_q(1, 0));
        chk({tag, "_e0_s0"}, 32'(d0[1]), ref_q(0, 0));
        chk({tag, "_e1_s4"}, 32'(d1[0]), ref_q(1, 4));
        chk({tag, "_e0_s4"}, 32'(d1[1]), ref_q(0, 4));
        if (!stl) begin
            chk({tag, "_latency"}, 32'(wcyc[0] - last_beat), 2);
            chk({tag, "_b2b"}, 32'(wcyc[1] - wcyc[0]), 1);
        end
        chk({tag, "_done_after_last"}, 32'(done_cyc - wcyc[1]), 1);
        chk({tag, "_busy_at_done"}, 32'(bus0.o_busy), 0);
        chk({tag, "_done1"}, 32'(bus1.o_done), 1);
        // start coinciding with done is dropped
        start = 1'b1; tick(); start = 1'b0;
        chk({tag, "_done_pulse"}, 32'(bus0.o_done), 0);
        chk({tag, "_start_at_done"}, 32'(bus0.o_busy), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; adc = '0; stall = 1'b0;
        tick(); tick();
        chk("rst_we", 32'(bus0.o_we), 0);
        chk("rst_data", 32'(bus0.o_data), 0);
        chk("rst_busy", 32'(bus0.o_busy), 0);
        chk("rst_done", 32'(bus0.o_done), 0);
        rst = 1'b0; tick();

        for (int k = 0; k < 4; k++) bt[k] = '0;
        run_vector("zero", 0, 0, 0);

        for (int k = 0; k < 4; k++) bt[k] = NB'(32'h1);
        run_vector("map", 0, 0, 0);

        for (int k = 0; k < 4; k++) bt[k] = '0;
        bt[3] = NB'(32'h0000_F000);
        run_vector("sat_b3", 0, 0, 0);
        for (int k = 0; k < 4; k++) bt[k] = '0;
        bt[0] = NB'(32'h0000_F000);
        run_vector("sat_b0", 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) begin
                bt[k] = (i % 2 == 0) ? (NB'($urandom) & NB'(32'h1111_3131)) : NB'($urandom);
            end
            run_vector("rand", i[0], i[1], i[2]);
        end

        // reset mid-ACCUM abandons the vector
        for (int k = 0; k < 4; k++) bt[k] = NB'(32'h1);
        run_vector("pre_rst", 0, 0, 0);
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            valid = 1'b1; adc = NB'($urandom); tick();
        end
        valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_we", 32'(bus0.o_we), 0);
        chk("midrst_data", 32'(bus0.o_data), 0);
        chk("midrst_busy", 32'(bus0.o_busy), 0);
        chk("midrst_done", 32'(bus0.o_done), 0);
        for (int s = 0; s < 6; s++) begin
            tick();
            chk("midrst_quiet", 32'({bus0.o_done, bus0.o_we, bus0.o_busy}), 0);
        end
        run_vector("post_rst", 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
